// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache line <-> block RAM transfer path.
//   state_e    : controller state (IDLE, WB, FILL, DONE)
//   WE_FULL    : RAM byte-enable pattern for a full-word write
//   *_DEF      : default line geometry used by the top-level parameters
//   line_word(): extracts word i from a packed line at the default geometry
package cache_mem_pkg;

  localparam int unsigned WIDTH_DEF      = 32;
  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned OFFS_W_DEF     = $clog2(LINE_WORDS_DEF);

  localparam logic [3:0] WE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  // Word i of a packed line; word 0 occupies the least-significant bits.
  function automatic logic [WIDTH_DEF-1:0] line_word(
    input logic [WIDTH_DEF*LINE_WORDS_DEF-1:0] line,
    input int unsigned                         i
  );
    return line[i*WIDTH_DEF +: WIDTH_DEF];
  endfunction

endpackage

// File: rtl/cache_line_mem_ctrl.sv
// Line-transfer controller between the cache controller and a word-wide
// block RAM. One request at a time; each request may write back a dirty line
// and/or refill a line. Writeback always precedes refill, so a wb+fill of the
// same line returns the freshly written data.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (ready only when idle)
//   req_wb, req_fill            operations contained in the request
//   wb_line_addr, fill_line_addr line addresses (word address = {line, idx})
//   wb_data                     writeback line, word i at [i*WIDTH +: WIDTH]
//   resp_valid                  one-cycle completion pulse
//   fill_data                   last refilled line, same packing as wb_data
//   mem_ena/wea/addra/dina      RAM port driven by this block
//   mem_douta                   RAM read data, valid in the same cycle
module cache_line_mem_ctrl
  import cache_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  localparam int unsigned OFFS_W    = $clog2(LINE_WORDS),
  localparam int unsigned LINE_AW   = ADDR_W - OFFS_W,
  localparam int unsigned LINE_BITS = WIDTH * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wb,
  input  logic                 req_fill,
  input  logic [LINE_AW-1:0]   wb_line_addr,
  input  logic [LINE_AW-1:0]   fill_line_addr,
  input  logic [LINE_BITS-1:0] wb_data,
  output logic                 resp_valid,
  output logic [LINE_BITS-1:0] fill_data,
  output logic                 mem_ena,
  output logic [3:0]           mem_wea,
  output logic [ADDR_W-1:0]    mem_addra,
  output logic [WIDTH-1:0]     mem_dina,
  input  logic [WIDTH-1:0]     mem_douta
);

  localparam logic [OFFS_W-1:0] LAST_IDX = OFFS_W'(LINE_WORDS - 1);

  state_e               state_q, state_d;
  logic [OFFS_W-1:0]    idx_q, idx_d;
  logic                 fill_q;
  logic [LINE_AW-1:0]   wb_line_q, fill_line_q;
  logic [LINE_BITS-1:0] wb_data_q, fill_data_q;

  logic accept;
  assign accept = req_valid && (state_q == IDLE);

  // The writeback flag itself is not stored: leaving IDLE for WB already
  // encodes it, and only the fill flag is needed later (at the end of WB).
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fill_q      <= 1'b0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
      // NOTE: the line buffers are plain flops, not RAM, so resetting them is
      // cheap and guarantees mem_dina and fill_data never carry X.
      wb_data_q   <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        fill_q      <= req_fill;
        wb_line_q   <= wb_line_addr;
        fill_line_q <= fill_line_addr;
        wb_data_q   <= wb_data;
      end
      if (state_q == FILL) begin
        fill_data_q[WIDTH*idx_q +: WIDTH] <= mem_douta;
      end
    end
  end

  // Next-state logic. The word counter wraps naturally back to 0 after the
  // last word because LINE_WORDS is a power of two.
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_wb)        state_d = WB;
          else if (req_fill) state_d = FILL;
          else               state_d = DONE;
        end
      end
      WB: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = fill_q ? FILL : DONE;
      end
      FILL: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port. Outside WB/FILL the address and data are parked at zero, which
  // keeps them stable and defined while the port is disabled.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wea   = 4'h0;
    mem_addra = '0;
    mem_dina  = '0;
    unique case (state_q)
      WB: begin
        mem_ena   = 1'b1;
        mem_wea   = WE_FULL;
        mem_addra = {wb_line_q, idx_q};
        mem_dina  = wb_data_q[WIDTH*idx_q +: WIDTH];
      end
      FILL: begin
        mem_ena   = 1'b1;
        mem_addra = {fill_line_q, idx_q};
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign fill_data  = fill_data_q;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Self-checking bench for cache_line_mem_ctrl: a table of directed requests
// with hand-computed latencies and line contents, plus hand-written
// sequences for back-to-back requests and reset in the middle of a writeback.
module tb_cache_line_mem_ctrl;
  import cache_mem_pkg::*;

  localparam int WIDTH = 32;
  localparam int ADDR_W = 14;
  localparam int LW = 8;
  localparam int LA = 11;
  localparam int LB = WIDTH * LW;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_wb;
  logic              req_fill;
  logic [LA-1:0]     wb_line_addr;
  logic [LA-1:0]     fill_line_addr;
  logic [LB-1:0]     wb_data;
  logic              resp_valid;
  logic [LB-1:0]     fill_data;
  logic              mem_ena;
  logic [3:0]        mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [WIDTH-1:0]  mem_dina;
  logic [WIDTH-1:0]  mem_douta;

  cache_line_mem_ctrl #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .LINE_WORDS(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill),
    .wb_line_addr(wb_line_addr), .fill_line_addr(fill_line_addr),
    .wb_data(wb_data),
    .resp_valid(resp_valid), .fill_data(fill_data),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  // Behavioural RAM: combinational read, write on the rising edge. The bench
  // preloads through a side port so the array has a single writing process.
  logic [WIDTH-1:0]  ram [0:(1<<ADDR_W)-1];
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [WIDTH-1:0]  pl_data;

  assign mem_douta = ram[mem_addra];

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_ena && mem_wea == WE_FULL) ram[mem_addra] <= mem_dina;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] make_line(input logic [WIDTH-1:0] base);
    logic [LB-1:0] l;
    for (int i = 0; i < LW; i++) l[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    return l;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        wb;
    logic        fill;
    logic [LA-1:0] wb_line;
    logic [LA-1:0] fill_line;
    logic [WIDTH-1:0] wb_base;
    int          exp_cycles;
    logic [WIDTH-1:0] exp_fill_base;
  } vec_t;

  vec_t vecs[5];

  // Issues one request, follows it cycle by cycle and checks the RAM port
  // schedule, the response latency and the resulting fill_data.
  task automatic run_vec(input vec_t v);
    int n_wb, n_ops, seen;
    logic [ADDR_W-1:0] exp_addr;
    n_wb  = v.wb ? LW : 0;
    n_ops = n_wb + (v.fill ? LW : 0);
    seen  = -1;
    @(negedge clk);
    req_valid = 1'b1; req_wb = v.wb; req_fill = v.fill;
    wb_line_addr = v.wb_line; fill_line_addr = v.fill_line;
    wb_data = make_line(v.wb_base);
    @(posedge clk);
    // Scramble inputs after accept: the registered request must be used.
    #1 req_valid = 1'b0; req_wb = 1'b1; req_fill = 1'b1;
    wb_line_addr = '1; fill_line_addr = '1; wb_data = '1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = c;
        check({v.name, " done_ena"}, mem_ena, 1'b0);
        break;
      end
      if (c <= n_ops) begin
        check({v.name, " ena"}, mem_ena, 1'b1);
        if (c <= n_wb) begin
          exp_addr = {v.wb_line, 3'(c - 1)};
          check({v.name, " wea_wr"}, mem_wea, 4'hF);
          check({v.name, " din"}, mem_dina, v.wb_base + WIDTH'(c - 1));
        end else begin
          exp_addr = {v.fill_line, 3'(c - 1 - n_wb)};
          check({v.name, " wea_rd"}, mem_wea, 4'h0);
        end
        check({v.name, " addr"}, mem_addra, exp_addr);
        check({v.name, " busy_ready"}, req_ready, 1'b0);
      end else begin
        check({v.name, " idle_ena"}, mem_ena, 1'b0);
      end
    end
    check({v.name, " latency"}, seen, v.exp_cycles);
    check({v.name, " fill_data"}, fill_data, make_line(v.exp_fill_base));
    @(negedge clk);
    check({v.name, " resp_pulse"}, resp_valid, 1'b0);
    check({v.name, " ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    int r1;
    logic busy_ok;
    logic [LB-1:0] l;

    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
    wb_line_addr = '0; fill_line_addr = '0; wb_data = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;

    // Preload happens while the DUT is held in reset.
    for (int i = 0; i < LW; i++) preload(14'h0040 + 14'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < LW; i++) preload(14'h3FF8 + 14'(i), 32'hBEEF0000 + 32'(i));
    for (int i = 0; i < LW; i++) preload(14'h0028 + 14'(i), 32'h0BAD0000 + 32'(i));
    for (int i = 0; i < LW; i++) preload(14'h0030 + 14'(i), 32'h77770000 + 32'(i));

    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_resp", resp_valid, 1'b0);
    check("rst_ena", mem_ena, 1'b0);
    check("rst_wea", mem_wea, 4'h0);
    check("rst_addr", mem_addra, '0);
    check("rst_din", mem_dina, '0);
    check("rst_fill", fill_data, '0);
    rst_n = 1'b1;

    vecs[0] = '{"fill8",   1'b0, 1'b1, 11'd0,    11'd8,    32'h0,        9,  32'hA0};
    vecs[1] = '{"wb3",     1'b1, 1'b0, 11'd3,    11'd0,    32'hDEAD0000, 9,  32'hA0};
    vecs[2] = '{"wbfill5", 1'b1, 1'b1, 11'd5,    11'd5,    32'h12340000, 17, 32'h12340000};
    vecs[3] = '{"none",    1'b0, 1'b0, 11'd1,    11'd1,    32'h0,        1,  32'h12340000};
    vecs[4] = '{"fill2047",1'b0, 1'b1, 11'd0,    11'd2047, 32'h0,        9,  32'hBEEF0000};

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    l = make_line(32'hDEAD0000);
    for (int i = 0; i < LW; i++) check("ram_wb3", ram[14'h0018 + 14'(i)], line_word(l, i));
    l = make_line(32'h12340000);
    for (int i = 0; i < LW; i++) check("ram_wb5", ram[14'h0028 + 14'(i)], line_word(l, i));

    // req_valid held high: wb+fill line 10, then the inputs switch to a
    // no-op request which must only be accepted after the first completes.
    @(negedge clk);
    req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b1;
    wb_line_addr = 11'd10; fill_line_addr = 11'd10;
    wb_data = make_line(32'h11110000);
    @(posedge clk);
    #1 req_wb = 1'b0; req_fill = 1'b0; wb_data = '0;
    r1 = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        r1 = c;
        break;
      end
      if (req_ready) busy_ok = 1'b0;
    end
    check("held_busy_ready", busy_ok, 1'b1);
    check("held_latency", r1, 17);
    check("held_fill", fill_data, make_line(32'h11110000));
    @(negedge clk);
    check("held_idle_ready", req_ready, 1'b1);
    check("held_idle_resp", resp_valid, 1'b0);
    @(negedge clk);
    check("held_second_resp", resp_valid, 1'b1);
    check("held_second_ena", mem_ena, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    check("held_end_resp", resp_valid, 1'b0);
    check("held_end_ready", req_ready, 1'b1);
    check("held_end_fill", fill_data, make_line(32'h11110000));

    // Reset during the third writeback cycle of line 6.
    @(negedge clk);
    req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b1;
    wb_line_addr = 11'd6; fill_line_addr = 11'd6;
    wb_data = make_line(32'hCAFE0000);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_wb_addr", mem_addra, 14'h0032);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ready", req_ready, 1'b1);
    check("async_rst_ena", mem_ena, 1'b0);
    check("async_rst_resp", resp_valid, 1'b0);
    check("async_rst_fill", fill_data, '0);
    check("async_rst_wea", mem_wea, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ena", mem_ena, 1'b0);
    check("ram_aborted_w0", ram[14'h0030], 32'hCAFE0000);
    check("ram_aborted_w1", ram[14'h0031], 32'hCAFE0001);
    for (int i = 2; i < LW; i++)
      check("ram_aborted_old", ram[14'h0030 + 14'(i)], 32'h77770000 + 32'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
